// File: rtl/aes_round_pipe.sv
// aes_round_pipe: back-pressurable four-stage AES encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey).
// Optional performance counters (blk_cnt, stall_cnt) when AES_ROUND_PERF_CNT_EN is defined.

// aes_sbox: combinational forward AES S-box
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    // Entry 0 sits in the top byte, so index from the top with the inverted address.
    assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_round_pipe #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    input  logic              in_final,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_final
`ifdef AES_ROUND_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);
    if (DATA_W != 128) begin : g_data_w_chk
        $error("aes_round_pipe: DATA_W must be 128");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_tag_w_chk
        $error("aes_round_pipe: TAG_W must be 1..16");
    end
    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("aes_round_pipe: CNT_W must be positive");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of the state is [127-8n -: 8]; row r, column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [3:0]        v;
    logic [3:0]        f;
    logic [DATA_W-1:0] d [4];
    logic [DATA_W-1:0] k [3];
    logic [TAG_W-1:0]  t [4];
    logic [DATA_W-1:0] sb, sr, mc, ark;
    logic              adv0, adv1, adv2, adv3;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (.a(in_data[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    end

    assign sr  = shift_rows(d[0]);
    assign mc  = f[1] ? d[1] : mix_columns(d[1]);
    assign ark = d[2] ^ k[2];

    // A stage moves forward when the stage ahead is empty or itself moving.
    assign adv3     = out_ready;
    assign adv2     = !v[3] || adv3;
    assign adv1     = !v[2] || adv2;
    assign adv0     = !v[1] || adv1;
    assign in_ready = !v[0] || adv0;

    assign out_valid = v[3];
    assign out_data  = d[3];
    assign out_tag   = t[3];
    assign out_final = f[3];

    // Pipeline registers: valids follow the advance chain, payload loads only when a real block moves in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            f <= '0;
            for (int i = 0; i < 4; i++) begin
                d[i] <= '0;
                t[i] <= '0;
            end
            for (int i = 0; i < 3; i++) k[i] <= '0;
        end else begin
            if (in_ready) v[0] <= in_valid;
            if (adv0) v[1] <= v[0];
            if (adv1) v[2] <= v[1];
            if (adv2) v[3] <= v[2];
            if (in_ready && in_valid) begin
                d[0] <= sb;
                k[0] <= in_key;
                f[0] <= in_final;
                t[0] <= in_tag;
            end
            if (adv0 && v[0]) begin
                d[1] <= sr;
                k[1] <= k[0];
                f[1] <= f[0];
                t[1] <= t[0];
            end
            if (adv1 && v[1]) begin
                d[2] <= mc;
                k[2] <= k[1];
                f[2] <= f[1];
                t[2] <= t[1];
            end
            if (adv2 && v[2]) begin
                d[3] <= ark;
                f[3] <= f[2];
                t[3] <= t[2];
            end
        end
    end

`ifdef AES_ROUND_PERF_CNT_EN
    // Saturating counts of delivered blocks and of cycles held by the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready && blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe: directed FIPS-197 vectors, back-pressure, reset and random handshake checks for aes_round_pipe.
module tb_aes_round_pipe;
    logic         clk = 0;
    logic         reset;
    logic         in_valid, in_ready, in_final;
    logic [127:0] in_data, in_key;
    logic [3:0]   in_tag;
    logic         out_valid, out_ready, out_final;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
`ifdef AES_ROUND_PERF_CNT_EN
    logic [31:0]  blk_cnt, stall_cnt;
`endif

    aes_round_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .in_final(in_final), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_final(out_final)
`ifdef AES_ROUND_PERF_CNT_EN
        , .blk_cnt(blk_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [127:0] DA = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KA = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] DB = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] KB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic [127:0] vin  [4] = '{DA, DB, DA, DA};
    logic [127:0] vkey [4] = '{KA, KB, KA, 128'h0};
    logic         vfin [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [127:0] vexp [4] = '{128'ha49c7ff2689f352b6b5bea43026a5049,
                               128'h3925841d02dc09fbdc118597196a0b32,
                               128'h7445a32768e07e1f9be228c8344beee0,
                               128'h046681e5e0cb199a48f8d37a2806264c};

    int checks = 0, errors = 0;
    int sent, rcv, n_blk, stalls, seen, cyc;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One handshake cycle: item s carries vector s%4 and tag s; every visible output is checked against item rcv.
    task automatic cycle(input bit vld, input bit rdy);
        in_valid  = vld && sent < n_blk;
        out_ready = rdy;
        if (in_valid) begin
            in_data  = vin[sent%4];
            in_key   = vkey[sent%4];
            in_final = vfin[sent%4];
            in_tag   = 4'(sent);
        end else begin
            in_data = 'x;
            in_key  = 'x;
        end
        @(negedge clk);
        if (out_valid) begin
            seen++;
            check("stream", {out_tag, out_final, out_data}, {4'(rcv), vfin[rcv%4], vexp[rcv%4]});
        end
        if (out_valid && !out_ready) stalls++;
        if (out_valid && out_ready) rcv++;
        if (in_valid && in_ready) sent++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1; in_valid = 0; out_ready = 0; in_data = 0; in_key = 0; in_final = 0; in_tag = 0;
        sent = 0; rcv = 0; n_blk = 0; stalls = 0; seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_final", out_final, 0);
        reset = 0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // FIPS-197 round 1 with exact latency
        in_valid = 1; in_data = DA; in_key = KA; in_final = 0; in_tag = 3; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("r1_early", out_valid, 0);
        @(posedge clk); #1;
        check("r1_valid", out_valid, 1);
        check("r1_data", out_data, vexp[0]);
        check("r1_tag", out_tag, 3);
        check("r1_final", out_final, 0);

        // FIPS-197 final round
        in_valid = 1; in_data = DB; in_key = KB; in_final = 1; in_tag = 9;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("fin_valid", out_valid, 1);
        check("fin_data", out_data, vexp[1]);
        check("fin_tag", out_tag, 9);
        check("fin_final", out_final, 1);
        @(posedge clk); #1;
        check("fin_drain", out_valid, 0);

        // Back-pressure: pipe fills with exactly four, then drains one per cycle in order
        sent = 0; rcv = 0; n_blk = 8;
        repeat (10) cycle(1, 0);
        check("bp_accepted", sent, 4);
        check("bp_in_ready", in_ready, 0);
        cyc = 0;
        while (rcv < 8 && cyc < 50) begin
            cycle(1, 1);
            cyc++;
        end
        check("bp_drain_cycles", cyc, 8);
        check("bp_sent", sent, 8);

        // Alternating final/non-final back-to-back
        sent = 0; rcv = 0; n_blk = 8;
        cyc = 0;
        while (rcv < 8 && cyc < 50) begin
            cycle(1, 1);
            cyc++;
        end
        check("alt_cycles", cyc, 12);

        // Reset with three blocks in flight
        sent = 0; rcv = 0; n_blk = 3;
        repeat (3) cycle(1, 0);
        cycle(0, 0);
        check("pre_rst_valid", out_valid, 1);
        reset = 1;
        #1;
        check("async_rst_valid", out_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        sent = 0; rcv = 0; n_blk = 0; stalls = 0; seen = 0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        repeat (10) cycle(0, 1);
        check("post_rst_stale", seen, 0);

        // Random valid/ready over 1000 blocks
        sent = 0; rcv = 0; n_blk = 1000;
        cyc = 0;
        while (rcv < 1000 && cyc < 20000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc++;
        end
        check("rnd_done", rcv, 1000);
`ifdef AES_ROUND_PERF_CNT_EN
        check("stall_cnt", stall_cnt, stalls);
        check("blk_cnt", blk_cnt, rcv);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
